muldiv_sequencer: RTL and testbench

Iterative 32-bit multiply/divide unit with its own sequencing FSM, attached beside the ALU in the execution stage. The execution stage presents a multi-cycle operation. The sequencer holds the stage stalled while a shift-add multiply or restoring divide runs, then releases the stall for exactly one cycle with the result valid. A flush from a program-counter change or a bubble aborts the operation in flight.

---
 rtl/muldiv_sequencer.sv | 158 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer for the execution stage: shift-add multiply and
// restoring divide, one iteration per cycle, with stall/flush handshake to the pipeline.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             flush,
    output logic             stall,
    output logic             resp_valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               resp_valid_q;
    logic               busy_q;
    logic [WIDTH-1:0]   result_lo_q, result_lo_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;

    logic               s1, s2;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dvs_d       = dvs_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        cnt_d       = cnt_q;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;

        s1   = req_op[0] & operand1[WIDTH-1];
        s2   = req_op[0] & operand2[WIDTH-1];
        abs1 = s1 ? -operand1 : operand1;
        abs2 = s2 ? -operand2 : operand2;

        // Multiply: accumulator is {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: accumulator is {partial remainder, dividend/quotient bits}.
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};
        div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod_fixed = neg_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_d   = req_op;
                    neg_d  = s1 ^ s2;
                    rneg_d = s1;
                    cnt_d  = '0;
                    if (req_op[1] && operand2 == '0) begin
                        state_d     = DONE;
                        result_lo_d = '1;
                        result_hi_d = operand1;
                    end else if (req_op == 2'b11 && operand1 == MIN_NEG && operand2 == '1) begin
                        state_d     = DONE;
                        result_lo_d = MIN_NEG;
                        result_hi_d = '0;
                    end else begin
                        state_d = RUN;
                        if (req_op[1]) begin
                            dvs_d = abs2;
                            acc_d = {{WIDTH{1'b0}}, abs1};
                        end else begin
                            dvs_d = abs1;
                            acc_d = {{WIDTH{1'b0}}, abs2};
                        end
                    end
                end
            end
            RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                if (op_q[1]) begin
                    result_lo_d = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    result_hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    result_lo_d = prod_fixed[WIDTH-1:0];
                    result_hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A bubble substituted mid-operation aborts exactly like a flush.
        if (flush || (!req_valid && (state_q == RUN || state_q == FIX))) begin
            state_d     = IDLE;
            result_lo_d = result_lo_q;
            result_hi_d = result_hi_q;
        end

        stall = req_valid & (state_q != DONE) & ~reset;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            result_lo_q  <= '0;
            result_hi_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= (state_d == DONE);
            busy_q       <= (state_d != IDLE);
            result_lo_q  <= result_lo_d;
            result_hi_q  <= result_hi_d;
        end
    end

    always_ff @(posedge clock) begin
        op_q   <= op_d;
        dvs_q  <= dvs_d;
        acc_q  <= acc_d;
        neg_q  <= neg_d;
        rneg_q <= rneg_d;
    end

    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
    assign result_lo  = result_lo_q;
    assign result_hi  = result_hi_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random ops against native
// arithmetic, and hand-written flush / bubble / reset / back-to-back sequences.
module tb_muldiv_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        flush;
    logic        stall;
    logic        resp_valid;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        busy;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .operand1(operand1), .operand2(operand2), .flush(flush), .stall(stall),
        .resp_valid(resp_valid), .result_lo(result_lo), .result_hi(result_hi), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        string       name;
    } exp_t;

    vec_t        vecs[14];
    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        logic [63:0] r;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        qa = $signed(a);
        qb = $signed(b);
        case (op)
            2'b00: r = {32'h0, a} * {32'h0, b};
            2'b01: r = sa * sb;
            2'b10: r = {a % b, a / b};
            default: r = {32'(qa % qb), 32'(qa / qb)};
        endcase
        return r;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] elo, input logic [31:0] ehi,
                         input string name);
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        operand1  = a;
        operand2  = b;
        if (push) begin
            e.lo = elo; e.hi = ehi; e.name = name;
            exp_q.push_back(e);
        end
    endtask

    // Counts cycles from the request's first cycle (n0 already elapsed) until resp_valid.
    task automatic wait_resp(input int lat, input int n0, output int at);
        int n = n0;
        bit got = 0;
        int bad_stall = 0;
        exp_t e;
        at = 0;
        while (!got && n < 100) begin
            @(negedge clock);
            if (resp_valid === 1'b1) got = 1;
            else begin
                if (stall !== 1'b1) bad_stall++;
                n++;
            end
        end
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard: response with no expectation queued");
            return;
        end
        e = exp_q.pop_front();
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s timeout: no resp_valid within 100 cycles", e.name);
            return;
        end
        at = cyc;
        chk({e.name, " latency"}, 64'(n), 64'(lat));
        chk({e.name, " stall_before_done"}, 64'(bad_stall), 64'd0);
        chk({e.name, " stall_at_done"}, {63'd0, stall}, 64'd0);
        chk({e.name, " busy_at_done"}, {63'd0, busy}, 64'd1);
        chk({e.name, " lo"}, {32'd0, result_lo}, {32'd0, e.lo});
        chk({e.name, " hi"}, {32'd0, result_hi}, {32'd0, e.hi});
        last_lo = e.lo;
        last_hi = e.hi;
    endtask

    task automatic no_resp(input int ncyc, input string name);
        int seen = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clock);
            if (resp_valid !== 1'b0) seen++;
        end
        chk({name, " no_resp_pulse"}, 64'(seen), 64'd0);
    endtask

    initial begin
        int at1, at2, t0;
        logic [31:0] ra, rb;
        logic [63:0] m;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 34, "mulu_max"};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 34, "mul_m3x7"};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, "div_m7d2"};
        vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'd14,       32'd2,        34, "divu_100d7"};
        vecs[4]  = '{2'b10, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1,  "divu_by0"};
        vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1,  "div_ovf"};
        vecs[6]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 34, "mul_minsq"};
        vecs[7]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        34, "div_7dm2"};
        vecs[8]  = '{2'b11, 32'h80000000, 32'd1,        32'h80000000, 32'd0,        34, "div_min_d1"};
        vecs[9]  = '{2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1,  "div_m5_by0"};
        vecs[10] = '{2'b00, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'd1,        34, "mulu_x2"};
        vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        34, "divu_d1"};
        vecs[12] = '{2'b01, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 34, "mul_7xm1"};
        vecs[13] = '{2'b10, 32'd3,        32'd10,       32'd0,        32'd3,        34, "divu_small"};

        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; operand1 = '0; operand2 = '0; flush = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset stall", {63'd0, stall}, 64'd0);
        chk("reset result", {result_hi, result_lo}, 64'd0);

        foreach (vecs[i]) begin
            @(posedge clock); #1;
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].lo, vecs[i].hi, vecs[i].name);
            wait_resp(vecs[i].lat, 0, at1);
            @(posedge clock); #1 req_valid = 1'b0;
        end

        for (int op = 0; op < 4; op++) begin
            for (int k = 0; k < 3; k++) begin
                ra = $urandom;
                rb = $urandom >> $urandom_range(0, 31);
                if (op[1] && rb == 0) rb = 32'd1;
                if (op == 3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
                m = model(2'(op), ra, rb);
                @(posedge clock); #1;
                drive(2'(op), ra, rb, 1'b1, m[31:0], m[63:32], $sformatf("rand_op%0d_%0d", op, k));
                wait_resp(34, 0, at1);
                @(posedge clock); #1 req_valid = 1'b0;
            end
        end

        // Flush at cycle 10 of a multiply, new divide presented the next cycle.
        @(posedge clock); #1;
        drive(2'b00, 32'd3, 32'd3, 1'b0, '0, '0, "");
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("flush pre resp_valid", {63'd0, resp_valid}, 64'd0);
            @(posedge clock); #1;
        end
        flush = 1'b1;
        @(negedge clock);
        chk("flush cycle10 resp_valid", {63'd0, resp_valid}, 64'd0);
        @(posedge clock); #1;
        flush = 1'b0;
        drive(2'b10, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, "flush_divu_9d3");
        @(negedge clock);
        chk("flush cycle11 busy", {63'd0, busy}, 64'd0);
        chk("flush cycle11 resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("flush results kept", {result_hi, result_lo}, {last_hi, last_lo});
        wait_resp(34, 1, at1);
        chk("flush resp absolute cycle", 64'(at1 - t0), 64'd45);
        @(posedge clock); #1 req_valid = 1'b0;

        // Bubble substituted mid-run aborts like a flush.
        @(posedge clock); #1;
        drive(2'b00, 32'd5, 32'd5, 1'b0, '0, '0, "");
        repeat (5) @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("bubble busy", {63'd0, busy}, 64'd0);
        no_resp(40, "bubble");
        chk("bubble results kept", {result_hi, result_lo}, {last_hi, last_lo});

        // Reset asserted at cycle 20 of a signed divide.
        @(posedge clock); #1;
        drive(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, '0, '0, "");
        repeat (20) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("reset_mid stall_forced_low", {63'd0, stall}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        chk("reset_mid busy", {63'd0, busy}, 64'd0);
        chk("reset_mid resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset_mid results", {result_hi, result_lo}, 64'd0);
        chk("reset_mid stall", {63'd0, stall}, 64'd0);
        no_resp(40, "reset_mid");
        last_lo = '0;
        last_hi = '0;

        // Back-to-back requests: the second is presented the cycle after DONE.
        @(posedge clock); #1;
        drive(2'b00, 32'd2, 32'd3, 1'b1, 32'd6, 32'd0, "b2b_first");
        wait_resp(34, 0, at1);
        @(posedge clock); #1;
        drive(2'b00, 32'd4, 32'd5, 1'b1, 32'd20, 32'd0, "b2b_second");
        wait_resp(34, 0, at2);
        chk("b2b pulse spacing", 64'(at2 - at1), 64'd35);
        @(posedge clock); #1 req_valid = 1'b0;
        @(negedge clock);
        chk("b2b idle after", {63'd0, busy}, 64'd0);

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
